// File: rtl/char_buf_pkg.sv
// Shared types for the character-buffer RAM arbiter: cell layout, clear FSM states and the
// per-cycle grant encoding.
package char_buf_pkg;

  localparam int unsigned H_COLS_DEF = 80;
  localparam int unsigned V_ROWS_DEF = 30;

  typedef struct packed {
    logic [11:0] front;
    logic [11:0] back;
    logic [7:0]  ch;
  } char_cell_t;

  typedef enum logic [1:0] {IDLE, PEND, CLEAR, DONE} clr_state_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_CPU, GNT_CLR} grant_t;

endpackage

// File: rtl/sync_wr_fifo.sv
// Small synchronous FIFO for buffered CPU cell writes; count and ready are registered.
module sync_wr_fifo #(
  parameter int unsigned WIDTH = 44,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic                       o_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_count_d;
  logic             r_ready;

  always_comb begin
    w_count_d = r_count;
    if (i_push && !i_pop) begin
      w_count_d = r_count + 1'b1;
    end else if (!i_push && i_pop) begin
      w_count_d = r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_d;
      r_ready <= (w_count_d < DEPTH_C);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_ready = r_ready;
  assign o_count = r_count;

endmodule

// File: rtl/char_buf_arbiter.sv
// Sole owner of the char_buf RAM port: VGA reads always win, then queued CPU writes, then the
// line/screen clear engine.
module char_buf_arbiter
  import char_buf_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_COLS     = H_COLS_DEF,
  parameter int unsigned V_ROWS     = V_ROWS_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_vga_req,
  input  logic [ADDR_W-1:0] i_vga_addr,
  output logic [DATA_W-1:0] o_vga_data,
  output logic              o_vga_valid,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_data,
  output logic              o_cpu_ready,
  output logic              o_cpu_ovf,
  input  logic              i_clr_start,
  input  logic              i_clr_all,
  input  logic [4:0]        i_clr_line,
  input  logic [DATA_W-1:0] i_clr_fill,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [6:0] H_LAST = 7'(H_COLS - 1);
  localparam logic [4:0] V_LAST = 5'(V_ROWS - 1);

  logic                     w_push, w_pop, w_empty, w_ready;
  logic [CNT_W-1:0]         w_count;
  logic [ADDR_W+DATA_W-1:0] w_head;
  grant_t                   w_gnt;

  clr_state_t       r_state;
  logic             r_busy, r_done, r_all;
  logic [4:0]       r_line;
  char_cell_t       r_fill;
  logic [6:0]       r_h;
  logic [4:0]       r_v;
  logic [CNT_W-1:0] r_pend_cnt;
  logic             r_vga_valid, r_ovf;

  assign w_push = i_cpu_we & w_ready & ~i_reset;
  // In PEND only entries queued before clr_start may retire; later ones wait for the clear.
  assign w_pop  = ~i_reset & ~i_vga_req & ~w_empty &
                  ((r_state == IDLE) | ((r_state == PEND) & (r_pend_cnt != '0)));

  sync_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({i_cpu_addr, i_cpu_data}),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_ready (w_ready),
    .o_count (w_count)
  );

  always_comb begin
    w_gnt = GNT_NONE;
    if (!i_reset) begin
      if (i_vga_req)               w_gnt = GNT_VGA;
      else if (w_pop)              w_gnt = GNT_CPU;
      else if (r_state == CLEAR)   w_gnt = GNT_CLR;
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    unique case (w_gnt)
      GNT_VGA: o_mem_addr = i_vga_addr;
      GNT_CPU: begin
        o_mem_addr  = w_head[ADDR_W+DATA_W-1 -: ADDR_W];
        o_mem_we    = 1'b1;
        o_mem_wdata = w_head[DATA_W-1:0];
      end
      GNT_CLR: begin
        o_mem_addr  = {r_h, r_v};
        o_mem_we    = 1'b1;
        o_mem_wdata = r_fill;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vga_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_vga_valid <= i_vga_req;
      if (i_cpu_we && !w_ready) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_all      <= 1'b0;
      r_line     <= '0;
      r_fill     <= '0;
      r_h        <= '0;
      r_v        <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_clr_start) begin
            r_state    <= PEND;
            r_busy     <= 1'b1;
            r_all      <= i_clr_all;
            r_line     <= i_clr_line;
            r_fill     <= i_clr_fill;
            r_pend_cnt <= w_count - CNT_W'(w_pop);
          end
        end
        PEND: begin
          if (w_pop) r_pend_cnt <= r_pend_cnt - 1'b1;
          if (r_pend_cnt == '0) begin
            r_state <= CLEAR;
            r_h     <= '0;
            r_v     <= r_all ? 5'd0 : r_line;
          end
        end
        CLEAR: begin
          if (w_gnt == GNT_CLR) begin
            if (r_h == H_LAST) begin
              r_h <= '0;
              if (!r_all || (r_v == V_LAST)) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_v <= r_v + 1'b1;
              end
            end else begin
              r_h <= r_h + 1'b1;
            end
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end

  assign o_vga_valid = r_vga_valid;
  assign o_vga_data  = r_vga_valid ? i_mem_rdata : '0;
  assign o_cpu_ready = w_ready;
  assign o_cpu_ovf   = r_ovf;
  assign o_clr_busy  = r_busy;
  assign o_clr_done  = r_done;

endmodule
